// File: rtl/mmu_pkg.sv
// mmu_pkg: shared state encoding, default sizes and operand slicing helper for the MMU feeder
package mmu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_e;

    localparam int LANES     = 4;
    localparam int BIT_WIDTH = 8;

    // LSB of element j of vector k inside a packed lanes x lanes tile
    function automatic int slice_lsb(input int bit_width, input int lanes, input int k, input int j);
        return bit_width * (k * lanes + j);
    endfunction

endpackage

// File: rtl/mmu_skew_lane.sv
// mmu_skew_lane: picks element (t - lane_idx) of one captured column, or 0 outside the tile window
module mmu_skew_lane #(
    parameter int bit_width = 8,
    parameter int lanes     = 4,
    parameter int cw        = 4
) (
    input  logic [cw-1:0]              lane_idx,
    input  logic [bit_width*lanes-1:0] col,
    input  logic [cw-1:0]              t,
    output logic [bit_width-1:0]       elem
);

    logic [cw-1:0] k;

    // lane j lags lane 0 by j cycles, so vector k reaches lane j at t = k + j
    always_comb begin
        k    = t - lane_idx;
        elem = '0;
        for (int i = 0; i < lanes; i++)
            elem = (t >= lane_idx && k == cw'(i)) ? col[i*bit_width +: bit_width] : elem;
    end

endmodule

// File: rtl/mmu_operand_feeder.sv
// mmu_operand_feeder: captures one operand tile and streams it diagonally skewed into the systolic MMU
module mmu_operand_feeder
    import mmu_pkg::*;
#(
    parameter int depth        = 32,
    parameter int bit_width    = BIT_WIDTH,
    parameter int lanes        = LANES,
    parameter int flush_cycles = 2 * LANES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [bit_width*lanes*lanes-1:0] in_data,
    input  logic [bit_width*lanes*lanes-1:0] in_wt,
    output logic [bit_width*depth-1:0]       data_arr,
    output logic [bit_width*depth-1:0]       wt_arr,
    output logic                             control,
    output logic                             mmu_clear,
    output logic                             busy,
    output logic                             done
);

    localparam int TW      = bit_width * lanes * lanes;
    localparam int AW      = bit_width * depth;
    localparam int CNT_MAX = (2 * lanes > flush_cycles) ? 2 * lanes : flush_cycles;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * lanes - 2);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((flush_cycles > 0) ? flush_cycles - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] data_q, data_d;
    logic [TW-1:0] wt_q, wt_d;

    logic [lanes-1:0][bit_width*lanes-1:0] d_col, w_col;
    logic [lanes-1:0][bit_width-1:0]       d_lane, w_lane;

    // state, cycle counter and captured tile registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            wt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wt_q    <= wt_d;
        end
    end

    // next-state: the counter restarts at 0 on every state entry and only advances in FEED and FLUSH
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        data_d  = data_q;
        wt_d    = wt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    wt_d    = in_wt;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = FEED;
            FEED: begin
                if (cnt_q == FEED_LAST)
                    state_d = (flush_cycles == 0) ? DONE : FLUSH;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST)
                    state_d = DONE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // regroup the tile so each lane sees its own column: element j of every vector k
    for (genvar j = 0; j < lanes; j++) begin : g_lane
        for (genvar k = 0; k < lanes; k++) begin : g_elem
            assign d_col[j][k*bit_width +: bit_width] = data_q[slice_lsb(bit_width, lanes, k, j) +: bit_width];
            assign w_col[j][k*bit_width +: bit_width] = wt_q[slice_lsb(bit_width, lanes, k, j) +: bit_width];
        end
        mmu_skew_lane #(
            .bit_width(bit_width),
            .lanes    (lanes),
            .cw       (CW)
        ) u_data_lane (
            .lane_idx(CW'(j)),
            .col     (d_col[j]),
            .t       (cnt_q),
            .elem    (d_lane[j])
        );
        mmu_skew_lane #(
            .bit_width(bit_width),
            .lanes    (lanes),
            .cw       (CW)
        ) u_wt_lane (
            .lane_idx(CW'(j)),
            .col     (w_col[j]),
            .t       (cnt_q),
            .elem    (w_lane[j])
        );
    end

    // outputs decoded purely from registered state; operands only leave the feeder during FEED
    always_comb begin
        in_ready  = state_q == IDLE;
        busy      = state_q != IDLE;
        control   = state_q == FEED || state_q == FLUSH;
        mmu_clear = state_q == CLEAR;
        done      = state_q == DONE;
        data_arr  = (state_q == FEED) ? AW'(d_lane) : '0;
        wt_arr    = (state_q == FEED) ? AW'(w_lane) : '0;
    end

endmodule

// File: tb/tb_mmu_operand_feeder.sv
// tb_mmu_operand_feeder: randomized and directed tiles checked against a phase-based reference model
module tb_mmu_operand_feeder;

    localparam int LANES = 4;
    localparam int BW    = 8;
    localparam int DEPTH = 32;
    localparam int FLUSH = 8;
    localparam int TW    = BW * LANES * LANES;
    localparam int AW    = BW * DEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [TW-1:0] in_data = '0;
    logic [TW-1:0] in_wt = '0;
    logic          in_ready, control, mmu_clear, busy, done;
    logic [AW-1:0] data_arr, wt_arr;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] snap_d [0:18];
    logic [AW-1:0] snap_w [0:18];

    always #5 clk = ~clk;

    mmu_operand_feeder #(
        .depth       (DEPTH),
        .bit_width   (BW),
        .lanes       (LANES),
        .flush_cycles(FLUSH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_wt    (in_wt),
        .data_arr (data_arr),
        .wt_arr   (wt_arr),
        .control  (control),
        .mmu_clear(mmu_clear),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] ctl();
        return AW'({in_ready, busy, control, mmu_clear, done});
    endfunction

    // phase p counts cycles after the accepting edge: 1 clear, 2..8 feed, 9..16 flush, 17 done, 18 idle
    function automatic logic [AW-1:0] ctl_exp(input int p);
        return AW'({p == 18, p >= 1 && p <= 17, p >= 2 && p <= 16, p == 1, p == 17});
    endfunction

    // lane j at feed step t carries element j of vector t-j
    function automatic logic [AW-1:0] skew(input logic [TW-1:0] v, input int t);
        logic [AW-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            int k;
            k = t - j;
            if (k >= 0 && k < LANES) r[BW*j +: BW] = v[BW*(k*LANES+j) +: BW];
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] rnd_tile();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // expects the accept on the coming edge; after the clear cycle either offers nxt (hold) or withdraws
    task automatic run_tile(input logic [TW-1:0] a_d, input logic [TW-1:0] a_w, input bit hold,
                            input logic [TW-1:0] nxt_d, input logic [TW-1:0] nxt_w, input string tag);
        for (int p = 1; p <= 18; p++) begin
            @(negedge clk);
            chk({tag, " ctl"}, ctl(), ctl_exp(p));
            chk({tag, " data"}, data_arr, (p >= 2 && p <= 8) ? skew(a_d, p - 2) : '0);
            chk({tag, " wt"}, wt_arr, (p >= 2 && p <= 8) ? skew(a_w, p - 2) : '0);
            snap_d[p] = data_arr;
            snap_w[p] = wt_arr;
            if (p == 1) begin
                in_data  = nxt_d;
                in_wt    = nxt_w;
                in_valid = hold;
            end
        end
    endtask

    initial begin
        logic [TW-1:0] pd, pw, a, aw, b, bw, c, cw;
        #1;
        chk("rst_hold ctl", ctl(), AW'(5'b10000));
        chk("rst_hold data", data_arr, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle ctl", ctl(), AW'(5'b10000));
        chk("idle data", data_arr, '0);
        chk("idle wt", wt_arr, '0);

        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < LANES; j++) begin
                pd[BW*(k*LANES+j) +: BW] = 8'(16 * k + j);
                pw[BW*(k*LANES+j) +: BW] = 8'(64 + 16 * k + j);
            end
        in_valid = 1'b1;
        in_data  = pd;
        in_wt    = pw;
        run_tile(pd, pw, 1'b0, rnd_tile(), rnd_tile(), "skew");
        chk("skew t0 data", snap_d[2], AW'(32'h00000000));
        chk("skew t0 wt", snap_w[2], AW'(32'h00000040));
        chk("skew t3 data", snap_d[5], AW'(32'h03122130));
        chk("skew t3 wt", snap_w[5], AW'(32'h43526170));
        chk("skew t6 data", snap_d[8], AW'(32'h33000000));
        chk("skew t6 wt", snap_w[8], AW'(32'h73000000));

        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            a  = rnd_tile();
            aw = rnd_tile();
            in_valid = 1'b1;
            in_data  = a;
            in_wt    = aw;
            run_tile(a, aw, 1'b0, rnd_tile(), rnd_tile(), "rand");
        end

        @(negedge clk);
        a  = rnd_tile();
        aw = rnd_tile();
        b  = rnd_tile();
        bw = rnd_tile();
        c  = rnd_tile();
        cw = rnd_tile();
        in_valid = 1'b1;
        in_data  = a;
        in_wt    = aw;
        run_tile(a, aw, 1'b1, b, bw, "hold1");
        run_tile(b, bw, 1'b1, c, cw, "hold2");
        run_tile(c, cw, 1'b0, rnd_tile(), rnd_tile(), "hold3");

        @(negedge clk);
        a  = rnd_tile();
        aw = rnd_tile();
        in_valid = 1'b1;
        in_data  = a;
        in_wt    = aw;
        for (int p = 1; p <= 4; p++) begin
            @(negedge clk);
            if (p == 1) in_valid = 1'b0;
        end
        chk("pre_rst data", data_arr, skew(a, 2));
        chk("pre_rst wt", wt_arr, skew(aw, 2));
        #2 reset = 1'b1;
        #1;
        chk("async_rst ctl", ctl(), AW'(5'b10000));
        chk("async_rst data", data_arr, '0);
        chk("async_rst wt", wt_arr, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post_rst idle", ctl(), AW'(5'b10000));
        end

        a  = rnd_tile();
        aw = rnd_tile();
        in_valid = 1'b1;
        in_data  = a;
        in_wt    = aw;
        run_tile(a, aw, 1'b0, rnd_tile(), rnd_tile(), "clean");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
